// File: rtl/score_counter_pkg.sv
// score_pkg: shared state encoding and default widths for the score_counter block.
// Revision 1.0
`default_nettype none

package score_pkg;

  localparam int DEF_CNT_W     = 16;
  localparam int DEF_MAX_SCORE = 999;
  localparam int MISS_W        = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PLAYING   = 2'd1,
    ST_GAME_OVER = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/score_counter_if.sv
// score_counter_if: player-input and score-output bundle between game logic and score_counter.
// Revision 1.0
`default_nettype none

interface score_counter_if
  import score_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic              start;
  logic              hit;
  logic [3:0]        hit_points;
  logic              miss;
  logic [CNT_W-1:0]  how_many;
  logic [CNT_W-1:0]  high_score;
  logic [MISS_W-1:0] misses;
  logic [1:0]        state;
  logic              game_over;
  logic              new_high;

  modport master (
    output start, hit, hit_points, miss,
    input  how_many, high_score, misses, state, game_over, new_high
  );

  modport slave (
    input  start, hit, hit_points, miss,
    output how_many, high_score, misses, state, game_over, new_high
  );

endinterface

`default_nettype wire

// File: rtl/score_counter_edge_detect.sv
// edge_detect: single-bit rising-edge detector, pulse is high for one cycle per 0->1 transition.
// Revision 1.0
`default_nettype none

module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev <= 1'b0;
    end else begin
      prev <= din;
    end
  end

  assign pulse = din & ~prev;

endmodule

`default_nettype wire

// File: rtl/score_counter.sv
// score_counter: weighted hit scoring with streak bonus, miss limit, saturation and session high score.
// Revision 1.0
`default_nettype none

module score_counter
  import score_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int MAX_SCORE    = DEF_MAX_SCORE,
  parameter int MISS_LIMIT   = 3,
  parameter int BONUS_STREAK = 5,
  parameter int BONUS_POINTS = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  score_counter_if.slave bus
);

  localparam int STREAK_W = 4;
  localparam logic [CNT_W:0]        MAX_EXT    = (CNT_W+1)'(MAX_SCORE);
  localparam logic [CNT_W:0]        BONUS_EXT  = (CNT_W+1)'(BONUS_POINTS);
  localparam logic [STREAK_W-1:0]   STREAK_TGT = STREAK_W'(BONUS_STREAK);
  localparam logic [MISS_W-1:0]     MISS_MAX   = MISS_W'(MISS_LIMIT);

  logic start_ev, hit_ev, miss_ev;

  edge_detect u_start_edge (.clk(clk), .rst_n(rst_n), .din(bus.start), .pulse(start_ev));
  edge_detect u_hit_edge   (.clk(clk), .rst_n(rst_n), .din(bus.hit),   .pulse(hit_ev));
  edge_detect u_miss_edge  (.clk(clk), .rst_n(rst_n), .din(bus.miss),  .pulse(miss_ev));

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    score_q, score_d;
  logic [CNT_W-1:0]    high_q, high_d;
  logic [MISS_W-1:0]   misses_q, misses_d, misses_inc;
  logic [STREAK_W-1:0] streak_q, streak_d, hit_streak;
  logic                new_high_q, new_high_d;
  logic [CNT_W:0]      sum;
  logic [CNT_W-1:0]    hit_score;
  logic                bonus;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      score_q    <= '0;
      high_q     <= '0;
      misses_q   <= '0;
      streak_q   <= '0;
      new_high_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      high_q     <= high_d;
      misses_q   <= misses_d;
      streak_q   <= streak_d;
      new_high_q <= new_high_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    high_d     = high_q;
    misses_d   = misses_q;
    streak_d   = streak_q;
    new_high_d = new_high_q;

    // Hit arithmetic is one bit wider so the clamp sees the true sum including bonus.
    hit_streak = streak_q + STREAK_W'(1);
    bonus      = (hit_streak == STREAK_TGT);
    sum        = {1'b0, score_q} + (CNT_W+1)'(bus.hit_points);
    if (bonus) begin
      sum = sum + BONUS_EXT;
    end
    hit_score  = (sum > MAX_EXT) ? MAX_EXT[CNT_W-1:0] : sum[CNT_W-1:0];
    misses_inc = misses_q + MISS_W'(1);

    if (start_ev) begin
      state_d    = ST_PLAYING;
      score_d    = '0;
      misses_d   = '0;
      streak_d   = '0;
      new_high_d = 1'b0;
    end else if (state_q == ST_PLAYING) begin
      if (hit_ev) begin
        score_d  = hit_score;
        streak_d = bonus ? '0 : hit_streak;
      end
      if (miss_ev) begin
        streak_d = '0;
        misses_d = misses_inc;
        if (misses_inc == MISS_MAX) begin
          state_d = ST_GAME_OVER;
          if (score_d > high_q) begin
            high_d     = score_d;
            new_high_d = 1'b1;
          end
        end
      end
    end else if (state_q != ST_IDLE && state_q != ST_GAME_OVER) begin
      state_d = ST_IDLE;
    end
  end

  assign bus.how_many   = score_q;
  assign bus.high_score = high_q;
  assign bus.misses     = misses_q;
  assign bus.state      = state_q;
  assign bus.game_over  = (state_q == ST_GAME_OVER);
  assign bus.new_high   = new_high_q;

endmodule

`default_nettype wire

// File: tb/tb_score_counter.sv
// tb_score_counter: directed stimulus with queued expectations checked by an independent monitor.
// Revision 1.0
`default_nettype none

module tb_score_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  score_counter_if #(.CNT_W(16)) bus ();

  score_counter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    string tag;
    int    score;
    int    high;
    int    mis;
    int    st;
    int    go;
    int    nh;
  } exp_t;

  exp_t sb_q[$];
  int   check_cnt = 0;
  int   pass_cnt  = 0;

  task automatic chk(input string name, input int act, input int exp);
    check_cnt++;
    if (act == exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk({e.tag, ".how_many"},   int'(bus.how_many),   e.score);
      chk({e.tag, ".high_score"}, int'(bus.high_score), e.high);
      chk({e.tag, ".misses"},     int'(bus.misses),     e.mis);
      chk({e.tag, ".state"},      int'(bus.state),      e.st);
      chk({e.tag, ".game_over"},  int'(bus.game_over),  e.go);
      chk({e.tag, ".new_high"},   int'(bus.new_high),   e.nh);
    end
  end

  task automatic expect_out(input string tag, input int score, input int high, input int mis,
                            input int st, input int go, input int nh);
    exp_t e;
    e.tag = tag; e.score = score; e.high = high; e.mis = mis;
    e.st = st; e.go = go; e.nh = nh;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hit_once(input logic [3:0] p);
    bus.hit = 1'b1; bus.hit_points = p; tick();
    bus.hit = 1'b0; tick();
  endtask

  task automatic miss_once();
    bus.miss = 1'b1; tick();
    bus.miss = 1'b0; tick();
  endtask

  task automatic start_once();
    bus.start = 1'b1; tick();
    bus.start = 1'b0; tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.hit = 1'b0; bus.miss = 1'b0; bus.hit_points = 4'd0;
    rst_n = 1'b0;
    tick(); tick();
    expect_out("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();

    hit_once(4'd5);
    expect_out("idle_hit", 0, 0, 0, 0, 0, 0);

    start_once();
    expect_out("start", 0, 0, 0, 1, 0, 0);
    hit_once(4'd2); hit_once(4'd2); hit_once(4'd2);
    expect_out("three_hits", 6, 0, 0, 1, 0, 0);

    bus.hit = 1'b1; bus.hit_points = 4'd2;
    repeat (10) tick();
    bus.hit = 1'b0; tick();
    expect_out("held_hit", 8, 0, 0, 1, 0, 0);

    miss_once();
    expect_out("first_miss", 8, 0, 1, 1, 0, 0);

    start_once();
    repeat (5) hit_once(4'd1);
    expect_out("bonus", 10, 0, 0, 1, 0, 0);

    start_once();
    repeat (4) hit_once(4'd1);
    miss_once();
    hit_once(4'd1);
    expect_out("streak_break", 5, 0, 1, 1, 0, 0);

    start_once();
    repeat (12) begin
      repeat (5) hit_once(4'd15);
    end
    hit_once(4'd15); hit_once(4'd15); hit_once(4'd7);
    expect_out("preload", 997, 0, 0, 1, 0, 0);
    hit_once(4'd9);
    expect_out("saturate", 999, 0, 0, 1, 0, 0);
    hit_once(4'd9); hit_once(4'd0);
    expect_out("sat_hold", 999, 0, 0, 1, 0, 0);

    bus.start = 1'b1; bus.hit = 1'b1; bus.hit_points = 4'd15; tick();
    bus.start = 1'b0; bus.hit = 1'b0; tick();
    expect_out("start_prio", 0, 0, 0, 1, 0, 0);

    miss_once(); miss_once();
    hit_once(4'd15); hit_once(4'd15); hit_once(4'd10);
    expect_out("pre_end", 40, 0, 2, 1, 0, 0);
    bus.hit = 1'b1; bus.miss = 1'b1; bus.hit_points = 4'd3; tick();
    bus.hit = 1'b0; bus.miss = 1'b0; tick();
    expect_out("game_over", 43, 43, 3, 2, 1, 1);
    hit_once(4'd5); miss_once();
    expect_out("go_ignore", 43, 43, 3, 2, 1, 1);

    start_once();
    expect_out("restart_go", 0, 43, 0, 1, 0, 0);
    hit_once(4'd15); hit_once(4'd5);
    miss_once(); miss_once(); miss_once();
    expect_out("round2_end", 20, 43, 3, 2, 1, 0);

    start_once();
    repeat (11) hit_once(4'd10);
    expect_out("pre_reset", 120, 43, 0, 1, 0, 0);
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    expect_out("mid_reset", 0, 0, 0, 0, 0, 0);
    tick();
    hit_once(4'd7);
    expect_out("post_reset_idle", 0, 0, 0, 0, 0, 0);

    tick(); tick();
    chk("scoreboard_drain", sb_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

`default_nettype wire
